// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan: N-channel, W-bit registered multiplexer with tri-state output.
// Manual mode selects a channel from sel. Auto-scan mode steps round-robin
// through the channels and holds each one for DWELL cycles. A one-cycle wrap
// pulse marks the step from channel N-1 to channel 0. When en is low the
// output releases the bus (high-Z) and the channel position is held.
module mux_nx1_scan #(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 1,
    parameter int unsigned SELW  = $clog2(N),
    parameter int unsigned DWELL = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  I,
    input  logic [SELW-1:0] sel,
    input  logic            en,
    input  logic            mode,
    output logic [W-1:0]    Y,
    output logic [SELW-1:0] ch,
    output logic            valid,
    output logic            wrap
);

    localparam int unsigned       CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNTW-1:0]   CNT_LAST = CNTW'(DWELL - 1);
    localparam logic [SELW-1:0]   CH_LAST  = SELW'(N - 1);
    localparam logic [SELW:0]     N_EXT    = (SELW + 1)'(N);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    state_e          state;
    logic [W-1:0]    chan [N];
    logic            sel_ok;

    logic [SELW-1:0] ch_q,   ch_d;
    logic [W-1:0]    y_q,    y_d;
    logic [CNTW-1:0] cnt_q,  cnt_d;
    logic            oe_q,   oe_d;
    logic            wrap_q, wrap_d;

    // Operating state is decoded from en and mode every cycle; it is not stored.
    always_comb begin
        state = ST_IDLE;
        if (en) begin
            state = mode ? ST_SCAN : ST_MANUAL;
        end
    end

    // Split the flat input bus into per-channel words; flag selects beyond N-1.
    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            chan[k] = I[k*W +: W];
        end
        sel_ok = ({1'b0, sel} < N_EXT);
    end

    // Next-state: pick the channel for this cycle, then load its data with it
    // so that Y and ch always describe the same channel.
    always_comb begin
        ch_d   = ch_q;
        y_d    = y_q;
        cnt_d  = cnt_q;
        oe_d   = en;
        wrap_d = 1'b0;
        case (state)
            ST_MANUAL: begin
                cnt_d = '0;
                if (sel_ok) begin
                    ch_d = sel;
                    y_d  = chan[sel];
                end
            end
            ST_SCAN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (ch_q == CH_LAST) begin
                        ch_d   = '0;
                        wrap_d = 1'b1;
                    end else begin
                        ch_d = ch_q + SELW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
                y_d = chan[ch_d];
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q   <= '0;
            y_q    <= '0;
            cnt_q  <= '0;
            oe_q   <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            ch_q   <= ch_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
            oe_q   <= oe_d;
            wrap_q <= wrap_d;
        end
    end

    assign Y     = oe_q ? y_q : 'z;
    assign ch    = ch_q;
    assign valid = oe_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Testbench for mux_nx1_scan: a 4-channel and a 3-channel instance (W=1,
// DWELL=4). The Y nets carry pullups, so a released bus reads as 1.
module tb_mux_nx1_scan;

    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] i4;
    logic [1:0] sel4;
    logic       en4, mode4;
    wire        y4;
    logic [1:0] ch4;
    logic       valid4, wrap4;

    logic [2:0] i3;
    logic [1:0] sel3;
    logic       en3, mode3;
    wire        y3;
    logic [1:0] ch3;
    logic       valid3, wrap3;

    pullup (y4);
    pullup (y3);

    mux_nx1_scan #(.N(4), .W(1), .DWELL(DW)) u4 (
        .clk(clk), .rst_n(rst_n), .I(i4), .sel(sel4), .en(en4), .mode(mode4),
        .Y(y4), .ch(ch4), .valid(valid4), .wrap(wrap4)
    );

    mux_nx1_scan #(.N(3), .W(1), .DWELL(DW)) u3 (
        .clk(clk), .rst_n(rst_n), .I(i3), .sel(sel3), .en(en3), .mode(mode3),
        .Y(y3), .ch(ch3), .valid(valid3), .wrap(wrap3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: channel position, dwell count, output data, enable, wrap.
    int m_ch [2];
    int m_cnt[2];
    bit m_y  [2];
    bit m_oe [2];
    bit m_wr [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ch[k] = 0; m_cnt[k] = 0; m_y[k] = 0; m_oe[k] = 0; m_wr[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit e, input bit m, input int s, input bit [3:0] iv);
        int n;
        n = (k == 0) ? 4 : 3;
        m_wr[k] = 0;
        m_oe[k] = e;
        if (!e) begin
            m_cnt[k] = 0;
        end else if (!m) begin
            m_cnt[k] = 0;
            if (s < n) begin
                m_ch[k] = s;
                m_y[k]  = iv[s];
            end
        end else begin
            if (m_cnt[k] == DW - 1) begin
                m_cnt[k] = 0;
                if (m_ch[k] == n - 1) m_wr[k] = 1;
                m_ch[k] = (m_ch[k] + 1) % n;
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
            end
            m_y[k] = iv[m_ch[k]];
        end
    endtask

    // One clock: inputs seen at the edge feed the model, outputs sampled 1 after.
    task automatic tick();
        bit e4, md4, e3, md3;
        int s4, s3;
        bit [3:0] v4, v3;
        e4 = en4; md4 = mode4; s4 = sel4; v4 = i4;
        e3 = en3; md3 = mode3; s3 = sel3; v3 = {1'b0, i3};
        @(posedge clk);
        #1;
        model_step(0, e4, md4, s4, v4);
        model_step(1, e3, md3, s3, v3);
    endtask

    typedef struct {
        logic       en;
        logic       mode;
        logic [1:0] sel;
        logic [3:0] i;
        logic       y;
        logic       valid;
        logic [1:0] ch;
        logic       wrap;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic e, input logic m, input logic [1:0] s, input logic [3:0] iv,
                                input logic y, input logic v, input logic [1:0] c, input logic w);
        vec_t t;
        t.en = e; t.mode = m; t.sel = s; t.i = iv;
        t.y = y; t.valid = v; t.ch = c; t.wrap = w;
        tbl.push_back(t);
    endfunction

    initial begin
        logic [3:0] pat;
        int c;

        // Manual select on the 4-channel instance with I=1010.
        add(0, 0, 0, 4'b1010, 1, 0, 0, 0);
        add(1, 0, 0, 4'b1010, 0, 1, 0, 0);
        add(1, 0, 1, 4'b1010, 1, 1, 1, 0);
        add(1, 0, 2, 4'b1010, 0, 1, 2, 0);
        add(1, 0, 3, 4'b1010, 1, 1, 3, 0);
        add(1, 0, 0, 4'b1010, 0, 1, 0, 0);
        // Scan with I=0110 from ch=0: a channel change every 4 edges, wrap on edge 16.
        pat = 4'b0110;
        for (int e = 1; e <= 25; e++) begin
            c = (e / 4) % 4;
            add(1, 1, 0, pat, pat[c], 1, 2'(c), (e == 16) ? 1'b1 : 1'b0);
        end
        // Now at ch=2, cnt=1: disable for two edges, then resume the full dwell.
        add(0, 1, 0, pat, 1, 0, 2, 0);
        add(0, 1, 0, pat, 1, 0, 2, 0);
        add(1, 1, 0, pat, 1, 1, 2, 0);
        add(1, 1, 0, pat, 1, 1, 2, 0);
        add(1, 1, 0, pat, 1, 1, 2, 0);
        add(1, 1, 0, pat, 0, 1, 3, 0);

        en4 = 1; mode4 = 0; sel4 = 0; i4 = 4'b1010;
        en3 = 0; mode3 = 0; sel3 = 0; i3 = 3'b000;

        // Asynchronous reset with no clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("reset.y_z", {7'b0, y4}, 8'd1);
        check("reset.valid", {7'b0, valid4}, 8'd0);
        check("reset.ch", {6'b0, ch4}, 8'd0);
        check("reset.wrap", {7'b0, wrap4}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[idx]) begin
            en4 = tbl[idx].en; mode4 = tbl[idx].mode; sel4 = tbl[idx].sel; i4 = tbl[idx].i;
            tick();
            check($sformatf("tbl[%0d].y", idx), {7'b0, y4}, {7'b0, tbl[idx].y});
            check($sformatf("tbl[%0d].valid", idx), {7'b0, valid4}, {7'b0, tbl[idx].valid});
            check($sformatf("tbl[%0d].ch", idx), {6'b0, ch4}, {6'b0, tbl[idx].ch});
            check($sformatf("tbl[%0d].wrap", idx), {7'b0, wrap4}, {7'b0, tbl[idx].wrap});
        end

        // Asynchronous reset mid-scan at ch=3.
        #2 rst_n = 1'b0;
        #1;
        check("midrst.y_z", {7'b0, y4}, 8'd1);
        check("midrst.valid", {7'b0, valid4}, 8'd0);
        check("midrst.ch", {6'b0, ch4}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        en4 = 1; mode4 = 1; i4 = 4'b0110;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("restart[%0d].ch", k), {6'b0, ch4}, 8'd0);
            check($sformatf("restart[%0d].y", k), {7'b0, y4}, 8'd0);
        end
        tick();
        check("restart[4].ch", {6'b0, ch4}, 8'd1);
        check("restart[4].y", {7'b0, y4}, 8'd1);
        for (int k = 5; k <= 15; k++) tick();
        check("pre_drop.ch", {6'b0, ch4}, 8'd3);
        // en falls exactly when the N-1 -> 0 step is due: no advance, no wrap.
        en4 = 0;
        tick();
        check("drop.ch", {6'b0, ch4}, 8'd3);
        check("drop.valid", {7'b0, valid4}, 8'd0);
        check("drop.wrap", {7'b0, wrap4}, 8'd0);
        en4 = 1;
        tick();
        check("resume.ch", {6'b0, ch4}, 8'd3);
        check("resume.valid", {7'b0, valid4}, 8'd1);
        check("resume.wrap", {7'b0, wrap4}, 8'd0);
        tick(); tick(); tick();
        check("resume_wrap.ch", {6'b0, ch4}, 8'd0);
        check("resume_wrap.wrap", {7'b0, wrap4}, 8'd1);
        tick();
        check("resume_wrap_end.wrap", {7'b0, wrap4}, 8'd0);

        // Out-of-range select on the 3-channel instance.
        en3 = 1; mode3 = 0; sel3 = 2'd1; i3 = 3'b010;
        tick();
        check("n3.sel1.y", {7'b0, y3}, 8'd1);
        check("n3.sel1.ch", {6'b0, ch3}, 8'd1);
        sel3 = 2'd3;
        tick();
        check("n3.sel3.y", {7'b0, y3}, 8'd1);
        check("n3.sel3.ch", {6'b0, ch3}, 8'd1);
        i3 = 3'b000;
        tick();
        check("n3.sel3_hold.y", {7'b0, y3}, 8'd1);
        check("n3.sel3_hold.valid", {7'b0, valid3}, 8'd1);

        // Randomized run of both instances against the reference model.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
        for (int n = 0; n < 400; n++) begin
            en4 = ($urandom_range(0, 7) != 0);
            en3 = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) mode4 = ~mode4;
            if ($urandom_range(0, 15) == 0) mode3 = ~mode3;
            sel4 = 2'($urandom_range(0, 3));
            sel3 = 2'($urandom_range(0, 3));
            i4 = 4'($urandom);
            i3 = 3'($urandom);
            tick();
            check($sformatf("rand4[%0d].y", n), {7'b0, y4}, {7'b0, m_oe[0] ? m_y[0] : 1'b1});
            check($sformatf("rand4[%0d].valid", n), {7'b0, valid4}, {7'b0, m_oe[0]});
            check($sformatf("rand4[%0d].ch", n), {6'b0, ch4}, 8'(m_ch[0]));
            check($sformatf("rand4[%0d].wrap", n), {7'b0, wrap4}, {7'b0, m_wr[0]});
            check($sformatf("rand3[%0d].y", n), {7'b0, y3}, {7'b0, m_oe[1] ? m_y[1] : 1'b1});
            check($sformatf("rand3[%0d].valid", n), {7'b0, valid3}, {7'b0, m_oe[1]});
            check($sformatf("rand3[%0d].ch", n), {6'b0, ch3}, 8'(m_ch[1]));
            check($sformatf("rand3[%0d].wrap", n), {7'b0, wrap3}, {7'b0, m_wr[1]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
